// File: rtl/phaser_out_tap_ctrl_pkg.sv
// Shared definitions for the PHASER_OUT tap-stepping controller: widths,
// parameter limits, FSM state type and the one-tap step helper.
`timescale 1ns/1ps
package phaser_out_ctrl_pkg;

  localparam int unsigned TAP_W        = 6;
  localparam int unsigned CNT_W        = 9;
  localparam int unsigned PACE_W       = 4;
  localparam int unsigned STEP_GAP_MIN = 1;
  localparam int unsigned STEP_GAP_MAX = 15;
  localparam int unsigned RD_LAT_MIN   = 1;
  localparam int unsigned RD_LAT_MAX   = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COARSE_STEP,
    ST_FINE_STEP,
    ST_GAP,
    ST_READ,
    ST_WAIT_RD,
    ST_FIN
  } state_e;

  // One tap toward tgt; callers only use it when cur != tgt, so no wrap.
  function automatic logic [TAP_W-1:0] tap_toward(input logic [TAP_W-1:0] cur,
                                                  input logic [TAP_W-1:0] tgt);
    return (tgt > cur) ? cur + TAP_W'(1) : cur - TAP_W'(1);
  endfunction

endpackage

// File: rtl/phaser_out_tap_ctrl_if.sv
// Request/response handshake plus PHASER_OUT control and status pins.
`timescale 1ns/1ps
interface phaser_out_tap_ctrl_if;
  import phaser_out_ctrl_pkg::*;

  logic             REQ_VALID;
  logic             REQ_READY;
  logic [TAP_W-1:0] REQ_FINE;
  logic [TAP_W-1:0] REQ_COARSE;
  logic             DONE;
  logic             ERR;
  logic [TAP_W-1:0] CUR_FINE;
  logic [TAP_W-1:0] CUR_COARSE;
  logic [CNT_W-1:0] RB_VAL;
  logic             FINEENABLE;
  logic             FINEINC;
  logic             COARSEENABLE;
  logic             COARSEINC;
  logic             COUNTERREADEN;
  logic             FINEOVERFLOW;
  logic             COARSEOVERFLOW;
  logic [CNT_W-1:0] COUNTERREADVAL;

  modport master (
    output REQ_VALID, REQ_FINE, REQ_COARSE, FINEOVERFLOW, COARSEOVERFLOW, COUNTERREADVAL,
    input  REQ_READY, DONE, ERR, CUR_FINE, CUR_COARSE, RB_VAL,
           FINEENABLE, FINEINC, COARSEENABLE, COARSEINC, COUNTERREADEN
  );

  modport slave (
    input  REQ_VALID, REQ_FINE, REQ_COARSE, FINEOVERFLOW, COARSEOVERFLOW, COUNTERREADVAL,
    output REQ_READY, DONE, ERR, CUR_FINE, CUR_COARSE, RB_VAL,
           FINEENABLE, FINEINC, COARSEENABLE, COARSEINC, COUNTERREADEN
  );
endinterface

// File: rtl/phaser_out_tap_ctrl_step_pacer.sv
// Loadable down-counter with zero flag; paces tap gaps and readback latency.
`timescale 1ns/1ps
module step_pacer
  import phaser_out_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic [PACE_W-1:0] load_val_i,
  output logic              zero_o
);

  logic [PACE_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - PACE_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/phaser_out_tap_ctrl.sv
// Steps PHASER_OUT coarse then fine taps one at a time toward a requested
// target, then reads back the delay counter and reports completion.
`timescale 1ns/1ps
module phaser_out_tap_ctrl
  import phaser_out_ctrl_pkg::*;
#(
  parameter int unsigned STEP_GAP    = 8,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned INIT_FINE   = 0,
  parameter int unsigned INIT_COARSE = 0
) (
  input logic                SYSCLK,
  input logic                RST_N,
  phaser_out_tap_ctrl_if.slave po
);

  localparam logic [TAP_W-1:0]  INIT_F      = TAP_W'(INIT_FINE);
  localparam logic [TAP_W-1:0]  INIT_C      = TAP_W'(INIT_COARSE);
  // Fine steps pass back through COARSE_STEP after GAP, so their gap is one
  // cycle shorter; both tap kinds then repeat every STEP_GAP+2 cycles.
  localparam logic [PACE_W-1:0] PACE_COARSE = PACE_W'(STEP_GAP);
  localparam logic [PACE_W-1:0] PACE_FINE   = PACE_W'(STEP_GAP - 1);
  localparam logic [PACE_W-1:0] PACE_RD     = PACE_W'(RD_LAT);

  state_e           state_q;
  logic             ready_q, done_q, err_q;
  logic             cen_q, cinc_q, fen_q, finc_q, rden_q;
  logic [CNT_W-1:0] rb_q;
  logic [TAP_W-1:0] cur_f_q, cur_c_q, tgt_f_q, tgt_c_q;

  logic              ovf;
  logic              pace_load_d;
  logic [PACE_W-1:0] pace_val_d;
  logic              pace_zero;

  assign ovf = po.FINEOVERFLOW | po.COARSEOVERFLOW;

  always_comb begin
    pace_load_d = 1'b0;
    pace_val_d  = '0;
    unique case (state_q)
      ST_COARSE_STEP: if (!ovf && tgt_c_q != cur_c_q) begin
        pace_load_d = 1'b1;
        pace_val_d  = PACE_COARSE;
      end
      ST_FINE_STEP: if (!ovf && tgt_f_q != cur_f_q) begin
        pace_load_d = 1'b1;
        pace_val_d  = PACE_FINE;
      end
      ST_READ: begin
        pace_load_d = 1'b1;
        pace_val_d  = PACE_RD;
      end
      default: ;
    endcase
  end

  step_pacer u_pacer (
    .clk_i      (SYSCLK),
    .rst_n_i    (RST_N),
    .load_i     (pace_load_d),
    .load_val_i (pace_val_d),
    .zero_o     (pace_zero)
  );

  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cen_q   <= 1'b0;
      cinc_q  <= 1'b0;
      fen_q   <= 1'b0;
      finc_q  <= 1'b0;
      rden_q  <= 1'b0;
      rb_q    <= '0;
      cur_f_q <= INIT_F;
      cur_c_q <= INIT_C;
      tgt_f_q <= INIT_F;
      tgt_c_q <= INIT_C;
    end else begin
      done_q <= 1'b0;
      cen_q  <= 1'b0;
      cinc_q <= 1'b0;
      fen_q  <= 1'b0;
      finc_q <= 1'b0;
      rden_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (po.REQ_VALID && ready_q) begin
            ready_q <= 1'b0;
            tgt_f_q <= po.REQ_FINE;
            tgt_c_q <= po.REQ_COARSE;
            err_q   <= 1'b0;
            state_q <= ST_COARSE_STEP;
          end
        end
        ST_COARSE_STEP: begin
          if (ovf) begin
            err_q   <= 1'b1;
            state_q <= ST_READ;
          end else if (tgt_c_q != cur_c_q) begin
            cen_q   <= 1'b1;
            cinc_q  <= (tgt_c_q > cur_c_q);
            cur_c_q <= tap_toward(cur_c_q, tgt_c_q);
            state_q <= ST_GAP;
          end else begin
            state_q <= ST_FINE_STEP;
          end
        end
        ST_FINE_STEP: begin
          if (ovf) begin
            err_q   <= 1'b1;
            state_q <= ST_READ;
          end else if (tgt_f_q != cur_f_q) begin
            fen_q   <= 1'b1;
            finc_q  <= (tgt_f_q > cur_f_q);
            cur_f_q <= tap_toward(cur_f_q, tgt_f_q);
            state_q <= ST_GAP;
          end else begin
            state_q <= ST_READ;
          end
        end
        ST_GAP: begin
          if (ovf) begin
            err_q   <= 1'b1;
            state_q <= ST_READ;
          end else if (pace_zero) begin
            state_q <= ST_COARSE_STEP;
          end
        end
        ST_READ: begin
          if (ovf) err_q <= 1'b1;
          rden_q  <= 1'b1;
          state_q <= ST_WAIT_RD;
        end
        ST_WAIT_RD: begin
          if (ovf) err_q <= 1'b1;
          if (pace_zero) begin
            rb_q    <= po.COUNTERREADVAL;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          if (ovf) err_q <= 1'b1;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign po.REQ_READY     = ready_q;
  assign po.DONE          = done_q;
  assign po.ERR           = err_q;
  assign po.CUR_FINE      = cur_f_q;
  assign po.CUR_COARSE    = cur_c_q;
  assign po.RB_VAL        = rb_q;
  assign po.FINEENABLE    = fen_q;
  assign po.FINEINC       = finc_q;
  assign po.COARSEENABLE  = cen_q;
  assign po.COARSEINC     = cinc_q;
  assign po.COUNTERREADEN = rden_q;

endmodule

// File: tb/tb_phaser_out_tap_ctrl.sv
// Scenario bench for phaser_out_tap_ctrl: tap-by-tap reference positions,
// pulse spacing, latency window, readback capture, overflow and reset abort.
`timescale 1ns/1ps
module tb_phaser_out_tap_ctrl;

  localparam int STEP_GAP = 8;
  localparam int RD_LAT   = 2;
  localparam int INIT_F   = 0;
  localparam int INIT_C   = 0;
  localparam int PERIOD   = STEP_GAP + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phaser_out_tap_ctrl_if bus ();

  phaser_out_tap_ctrl #(
    .STEP_GAP    (STEP_GAP),
    .RD_LAT      (RD_LAT),
    .INIT_FINE   (INIT_F),
    .INIT_COARSE (INIT_C)
  ) dut (
    .SYSCLK (clk),
    .RST_N  (rst_n),
    .po     (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference tap position, updated from each request's targets.
  int mc = INIT_C;
  int mf = INIT_F;

  int c_cyc[$];
  bit c_inc[$];
  int f_cyc[$];
  bit f_inc[$];
  int rd_cyc[$];
  int proto_err = 0;
  bit prev_c = 1'b0, prev_f = 1'b0;
  int cb, fb, rbb, pb;

  always @(negedge clk) begin
    if (bus.COARSEENABLE) begin c_cyc.push_back(cyc); c_inc.push_back(bus.COARSEINC); end
    if (bus.FINEENABLE)   begin f_cyc.push_back(cyc); f_inc.push_back(bus.FINEINC);   end
    if (bus.COUNTERREADEN) rd_cyc.push_back(cyc);
    if (bus.COARSEENABLE && bus.FINEENABLE) proto_err++;
    if (!bus.COARSEENABLE && bus.COARSEINC) proto_err++;
    if (!bus.FINEENABLE && bus.FINEINC) proto_err++;
    if ((bus.COARSEENABLE && prev_c) || (bus.FINEENABLE && prev_f)) proto_err++;
    prev_c = bus.COARSEENABLE;
    prev_f = bus.FINEENABLE;
  end

  // Counter readback source: a fresh value each cycle, remembered by cycle.
  logic [8:0] ring [16];
  bit         fixed_rd = 1'b0;
  logic [8:0] fixed_val = '0;
  initial begin
    logic [8:0] v;
    bus.COUNTERREADVAL = '0;
    forever begin
      @(negedge clk);
      v = fixed_rd ? fixed_val : 9'($urandom);
      bus.COUNTERREADVAL = v;
      ring[cyc % 16] = v;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic issue(input int tc, input int tf, input bit hold, output int acc, output bit ok);
    ok = 1'b0;
    acc = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (bus.REQ_READY) begin
        bus.REQ_VALID  = 1'b1;
        bus.REQ_COARSE = 6'(tc);
        bus.REQ_FINE   = 6'(tf);
        @(posedge clk);
        #1;
        acc = cyc;
        ok  = 1'b1;
        cb  = c_cyc.size();
        fb  = f_cyc.size();
        rbb = rd_cyc.size();
        pb  = proto_err;
        if (!hold) begin
          @(negedge clk);
          bus.REQ_VALID = 1'b0;
        end
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL issue_accept: REQ_READY never high, got %0b want 1", bus.REQ_READY);
    end
  endtask

  task automatic wait_done(input int budget, output int dcyc, output bit ok);
    ok = 1'b0;
    dcyc = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.DONE) begin ok = 1'b1; dcyc = cyc; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL done_timeout: no DONE within %0d cycles, got 0 want 1", budget);
    end
  endtask

  // One complete move from the reference position to (tc, tf).
  task automatic do_move(input string nm, input int tc, input int tf);
    int nc, nf, acc, dcyc, bad, lat, expl;
    bit ci, fi, ok;
    logic [8:0] exp_rb;
    nc = (tc > mc) ? tc - mc : mc - tc;
    nf = (tf > mf) ? tf - mf : mf - tf;
    ci = (tc > mc);
    fi = (tf > mf);
    issue(tc, tf, 1'b0, acc, ok);
    if (!ok) return;
    wait_done((nc + nf) * PERIOD + RD_LAT + 20, dcyc, ok);
    if (!ok) return;

    tests++;
    if (c_cyc.size() - cb !== nc || f_cyc.size() - fb !== nf) begin
      fails++;
      $display("FAIL %s pulse_count: got coarse=%0d fine=%0d want coarse=%0d fine=%0d",
               nm, c_cyc.size() - cb, f_cyc.size() - fb, nc, nf);
    end
    bad = 0;
    for (int i = cb; i < c_cyc.size(); i++) if (c_inc[i] !== ci) bad++;
    for (int i = fb; i < f_inc.size(); i++) if (f_inc[i] !== fi) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL %s inc_dir: %0d pulses with wrong INC, want 0 (coarse inc=%0b fine inc=%0b)", nm, bad, ci, fi);
    end
    bad = 0;
    for (int i = cb + 1; i < c_cyc.size(); i++) if (c_cyc[i] - c_cyc[i-1] != PERIOD) bad++;
    for (int i = fb + 1; i < f_cyc.size(); i++) if (f_cyc[i] - f_cyc[i-1] != PERIOD) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL %s spacing: %0d pulse intervals differ from %0d, want 0", nm, bad, PERIOD);
    end
    if (nc > 0 && nf > 0) begin
      tests++;
      if (c_cyc[c_cyc.size()-1] >= f_cyc[fb]) begin
        fails++;
        $display("FAIL %s order: last coarse at %0d, first fine at %0d, want coarse first",
                 nm, c_cyc[c_cyc.size()-1], f_cyc[fb]);
      end
    end
    expl = (nc + nf) * PERIOD + RD_LAT + 4;
    lat  = dcyc - acc;
    tests++;
    if (lat < expl - 1 || lat > expl + 1) begin
      fails++;
      $display("FAIL %s latency: got %0d want %0d +/-1", nm, lat, expl);
    end
    tests++;
    if ({bus.CUR_COARSE, bus.CUR_FINE} !== {6'(tc), 6'(tf)}) begin
      fails++;
      $display("FAIL %s cur_pos: got %0d/%0d want %0d/%0d", nm, bus.CUR_COARSE, bus.CUR_FINE, tc, tf);
    end
    tests++;
    if (bus.ERR !== 1'b0) begin
      fails++;
      $display("FAIL %s err: got %0b want 0", nm, bus.ERR);
    end
    tests++;
    if (rd_cyc.size() - rbb !== 1) begin
      fails++;
      $display("FAIL %s readen_count: got %0d want 1", nm, rd_cyc.size() - rbb);
    end else begin
      exp_rb = ring[(rd_cyc[rd_cyc.size()-1] + RD_LAT) % 16];
      tests++;
      if (bus.RB_VAL !== exp_rb) begin
        fails++;
        $display("FAIL %s rb_val: got %h want %h", nm, bus.RB_VAL, exp_rb);
      end
    end
    tests++;
    if (proto_err !== pb) begin
      fails++;
      $display("FAIL %s pin_protocol: %0d enable/inc violations, want 0", nm, proto_err - pb);
    end
    tests++;
    if (bus.REQ_READY !== 1'b0) begin
      fails++;
      $display("FAIL %s ready_at_done: got %0b want 0", nm, bus.REQ_READY);
    end
    @(negedge clk);
    tests++;
    if (bus.REQ_READY !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_after_done: got %0b want 1", nm, bus.REQ_READY);
    end
    mc = tc;
    mf = tf;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.REQ_READY, bus.DONE, bus.ERR, bus.COARSEENABLE, bus.COARSEINC,
         bus.FINEENABLE, bus.FINEINC, bus.COUNTERREADEN, bus.RB_VAL} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%0b done=%0b err=%0b rb=%h want all 0",
               bus.REQ_READY, bus.DONE, bus.ERR, bus.RB_VAL);
    end
    tests++;
    if ({bus.CUR_COARSE, bus.CUR_FINE} !== {6'(INIT_C), 6'(INIT_F)}) begin
      fails++;
      $display("FAIL reset_cur: got %0d/%0d want %0d/%0d", bus.CUR_COARSE, bus.CUR_FINE, INIT_C, INIT_F);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.REQ_READY !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_before_edge: got %0b want 0", bus.REQ_READY);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.REQ_READY !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_first_edge: got %0b want 1", bus.REQ_READY);
    end
  endtask

  task automatic test_same_position();
    fixed_rd  = 1'b1;
    fixed_val = 9'h1A5;
    do_move("same_pos", mc, mf);
    tests++;
    if (bus.RB_VAL !== 9'h1A5) begin
      fails++;
      $display("FAIL same_pos_rb: got %h want 1a5", bus.RB_VAL);
    end
    fixed_rd = 1'b0;
  endtask

  task automatic test_overflow();
    int tf, acc, dcyc, cnt, f0;
    bit ok, up;
    up = (mf <= 57);
    tf = up ? mf + 6 : mf - 6;
    issue(mc, tf, 1'b0, acc, ok);
    if (!ok) return;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 3; i++) begin
      if (bus.FINEENABLE) cnt++;
      if (cnt < 3) @(negedge clk);
    end
    bus.FINEOVERFLOW = 1'b1;
    @(negedge clk);
    bus.FINEOVERFLOW = 1'b0;
    wait_done(200, dcyc, ok);
    if (!ok) return;
    tests++;
    if (f_cyc.size() - fb !== 3 || c_cyc.size() - cb !== 0) begin
      fails++;
      $display("FAIL ovf_pulses: got fine=%0d coarse=%0d want fine=3 coarse=0", f_cyc.size() - fb, c_cyc.size() - cb);
    end
    tests++;
    if (bus.ERR !== 1'b1) begin
      fails++;
      $display("FAIL ovf_err: got %0b want 1", bus.ERR);
    end
    mf = up ? mf + 3 : mf - 3;
    tests++;
    if ({bus.CUR_COARSE, bus.CUR_FINE} !== {6'(mc), 6'(mf)}) begin
      fails++;
      $display("FAIL ovf_cur: got %0d/%0d want %0d/%0d", bus.CUR_COARSE, bus.CUR_FINE, mc, mf);
    end
    tests++;
    if (rd_cyc.size() - rbb !== 1) begin
      fails++;
      $display("FAIL ovf_readen: got %0d want 1", rd_cyc.size() - rbb);
    end
    f0 = f_cyc.size();
    repeat (5) @(negedge clk);
    tests++;
    if (bus.ERR !== 1'b1 || f_cyc.size() !== f0) begin
      fails++;
      $display("FAIL ovf_sticky: got err=%0b new_pulses=%0d want err=1 new_pulses=0", bus.ERR, f_cyc.size() - f0);
    end
    issue(mc, mf, 1'b0, acc, ok);
    if (!ok) return;
    tests++;
    if (bus.ERR !== 1'b0) begin
      fails++;
      $display("FAIL ovf_err_clear: got %0b want 0", bus.ERR);
    end
    wait_done(50, dcyc, ok);
    if (!ok) return;
    tests++;
    if (bus.ERR !== 1'b0) begin
      fails++;
      $display("FAIL ovf_err_after_done: got %0b want 0", bus.ERR);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int tc, acc, bad;
    bit ok, seen;
    tc = (mc <= 61) ? mc + 2 : mc - 2;
    issue(tc, mf, 1'b0, acc, ok);
    if (!ok) return;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.COARSEENABLE) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL rstmid_pulse: got no coarse pulse, want 1");
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.REQ_READY, bus.DONE, bus.ERR, bus.COARSEENABLE, bus.COARSEINC,
         bus.FINEENABLE, bus.FINEINC, bus.COUNTERREADEN, bus.RB_VAL} !== '0) begin
      fails++;
      $display("FAIL rstmid_outputs: got rdy=%0b done=%0b err=%0b rb=%h want all 0",
               bus.REQ_READY, bus.DONE, bus.ERR, bus.RB_VAL);
    end
    tests++;
    if ({bus.CUR_COARSE, bus.CUR_FINE} !== {6'(INIT_C), 6'(INIT_F)}) begin
      fails++;
      $display("FAIL rstmid_cur: got %0d/%0d want %0d/%0d", bus.CUR_COARSE, bus.CUR_FINE, INIT_C, INIT_F);
    end
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.DONE || bus.COARSEENABLE || bus.FINEENABLE || bus.COUNTERREADEN || bus.REQ_READY) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL rstmid_quiet: %0d active cycles during reset, want 0", bad);
    end
    rst_n = 1'b1;
    mc = INIT_C;
    mf = INIT_F;
    @(posedge clk);
    #1;
    tests++;
    if (bus.REQ_READY !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_ready: got %0b want 1", bus.REQ_READY);
    end
  endtask

  task automatic test_back_to_back();
    int tc, tf, nsteps, acc, bad;
    bit ok, done;
    tc = int'($urandom_range(0, 20));
    tf = int'($urandom_range(0, 20));
    nsteps = ((tc > mc) ? tc - mc : mc - tc) + ((tf > mf) ? tf - mf : mf - tf);
    issue(tc, tf, 1'b1, acc, ok);
    if (!ok) return;
    bad = 0;
    done = 1'b0;
    for (int i = 0; i < nsteps * PERIOD + RD_LAT + 20 && !done; i++) begin
      @(negedge clk);
      if (bus.DONE) begin
        done = 1'b1;
        bus.REQ_VALID = 1'b0;
      end else begin
        if (bus.REQ_READY) bad++;
        bus.REQ_COARSE = 6'($urandom);
        bus.REQ_FINE   = 6'($urandom);
      end
    end
    bus.REQ_VALID = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL busy_done: got no DONE, want DONE");
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL busy_ready: REQ_READY high in %0d busy cycles, want 0", bad);
    end
    tests++;
    if ({bus.CUR_COARSE, bus.CUR_FINE} !== {6'(tc), 6'(tf)}) begin
      fails++;
      $display("FAIL busy_target: got %0d/%0d want %0d/%0d", bus.CUR_COARSE, bus.CUR_FINE, tc, tf);
    end
    tests++;
    if ((c_cyc.size() - cb) + (f_cyc.size() - fb) !== nsteps) begin
      fails++;
      $display("FAIL busy_steps: got %0d want %0d", (c_cyc.size() - cb) + (f_cyc.size() - fb), nsteps);
    end
    @(negedge clk);
    tests++;
    if (bus.REQ_READY !== 1'b1) begin
      fails++;
      $display("FAIL busy_ready_after: got %0b want 1", bus.REQ_READY);
    end
    mc = tc;
    mf = tf;
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      do_move("random", int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
  endtask

  initial begin
    bus.REQ_VALID      = 1'b0;
    bus.REQ_FINE       = '0;
    bus.REQ_COARSE     = '0;
    bus.FINEOVERFLOW   = 1'b0;
    bus.COARSEOVERFLOW = 1'b0;
    test_reset();
    do_move("basic", 3, 5);
    do_move("decrement", 1, 63);
    test_same_position();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
